// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencing unit.
package slc3_pkg;

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22, S12,
        S04, S21, S20, S06, S07,
        S25, S27, S23, S16, PAUSE1, PAUSE2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    // States that hold an SRAM access for MEM_WAIT cycles.
    function automatic logic is_mem_state(state_t s);
        return (s == S33) || (s == S25) || (s == S16);
    endfunction

endpackage

// File: rtl/slc3_control_if.sv
// Control bundle between the ISDU (master) and the SLC-3 datapath/SRAM (slave).
interface slc3_control_if;
    logic       Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DR, SR1MUX, ADDR1MUX, MIO_EN;
    logic       Mem_CE_N, Mem_OE_N, Mem_WE_N;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DR, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN,
               Mem_CE_N, Mem_OE_N, Mem_WE_N
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DR, SR1MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN,
               Mem_CE_N, Mem_OE_N, Mem_WE_N
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter for SRAM access states; done_o marks the final cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);
    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    logic [2:0] cnt_q, cnt_d;

    assign done_o = en_i && (cnt_q == LAST);

    // Wrapping to zero on done keeps back-to-back entries aligned.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || done_o) cnt_d = '0;
        else if (en_i)       cnt_d = cnt_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/slc3_control.sv
// SLC-3 ISDU: Moore FSM driving datapath loads, gates, mux selects and SRAM strobes.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    slc3_control_if.master bus
);
    state_t state_q, state_d;
    logic   mem_done;
    logic   in_mem;

    assign in_mem = is_mem_state(state_q);

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .clk   (clk),
        .rst   (reset),
        .clr_i (!in_mem),
        .en_i  (in_mem),
        .done_o(mem_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED: if (bus.Run) state_d = S18;
            S18:    state_d = S33;
            S33:    if (mem_done) state_d = S35;
            S35:    state_d = S32;
            S32: begin
                case (bus.Opcode)
                    OP_ADD:   state_d = S01;
                    OP_AND:   state_d = S05;
                    OP_NOT:   state_d = S09;
                    OP_BR:    state_d = S00;
                    OP_JMP:   state_d = S12;
                    OP_JSR:   state_d = S04;
                    OP_LDR:   state_d = S06;
                    OP_STR:   state_d = S07;
                    OP_PAUSE: state_d = PAUSE1;
                    default:  state_d = S18;
                endcase
            end
            S00:    state_d = bus.BEN ? S22 : S18;
            S04:    state_d = bus.IR_11 ? S21 : S20;
            S06:    state_d = S25;
            S07:    state_d = S23;
            S25:    if (mem_done) state_d = S27;
            S23:    state_d = S16;
            S16:    if (mem_done) state_d = S18;
            PAUSE1: if (bus.Continue) state_d = PAUSE2;
            PAUSE2: if (!bus.Continue) state_d = S18;
            S01, S05, S09, S22, S12, S21, S20, S27: state_d = S18;
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HALTED;
        else       state_q <= state_d;
    end

    // Decoded from the async-reset state so strobes drop with reset, not a clock edge.
    always_comb begin
        bus.LD_MAR = 1'b0; bus.LD_MDR = 1'b0; bus.LD_IR  = 1'b0; bus.LD_BEN = 1'b0;
        bus.LD_CC  = 1'b0; bus.LD_REG = 1'b0; bus.LD_PC  = 1'b0; bus.LD_LED = 1'b0;
        bus.GatePC = 1'b0; bus.GateMDR = 1'b0; bus.GateALU = 1'b0; bus.GateMARMUX = 1'b0;
        bus.PCMUX  = PCMUX_INC; bus.ADDR2MUX = ADDR2_ZERO; bus.ALUK = ALUK_ADD;
        bus.DR = 1'b0; bus.SR1MUX = 1'b0; bus.ADDR1MUX = 1'b0; bus.MIO_EN = 1'b0;
        bus.Mem_CE_N = 1'b1; bus.Mem_OE_N = 1'b1; bus.Mem_WE_N = 1'b1;
        case (state_q)
            S18: begin
                bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.PCMUX = PCMUX_INC; bus.LD_PC = 1'b1;
            end
            S33, S25: begin
                bus.Mem_CE_N = 1'b0; bus.Mem_OE_N = 1'b0; bus.LD_MDR = mem_done;
            end
            S35: begin
                bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
            end
            S32: bus.LD_BEN = 1'b1;
            S01, S05, S09: begin
                bus.SR1MUX = 1'b1; bus.DR = 1'b1; bus.GateALU = 1'b1;
                bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
                bus.ALUK = (state_q == S01) ? ALUK_ADD :
                           (state_q == S05) ? ALUK_AND : ALUK_NOT;
            end
            S22: begin
                bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_SEXT9;
                bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
            end
            S12, S20: begin
                bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b0; bus.ADDR2MUX = ADDR2_ZERO;
                bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
            end
            S04: begin
                bus.GatePC = 1'b1; bus.DR = 1'b0; bus.LD_REG = 1'b1;
            end
            S21: begin
                bus.ADDR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_SEXT11;
                bus.PCMUX = PCMUX_ADDER; bus.LD_PC = 1'b1;
            end
            S06, S07: begin
                bus.SR1MUX = 1'b1; bus.ADDR1MUX = 1'b0; bus.ADDR2MUX = ADDR2_SEXT6;
                bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
            end
            S27: begin
                bus.GateMDR = 1'b1; bus.DR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
            end
            S23: begin
                bus.SR1MUX = 1'b0; bus.ALUK = ALUK_PASS; bus.GateALU = 1'b1;
                bus.MIO_EN = 1'b1; bus.LD_MDR = 1'b1;
            end
            S16: begin
                bus.Mem_CE_N = 1'b0; bus.Mem_WE_N = 1'b0; bus.Mem_OE_N = 1'b1;
            end
            PAUSE1: bus.LD_LED = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control: per-cycle expected control words queued and checked.
module tb_slc3_control;
    import slc3_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    slc3_control_if bus();

    slc3_control #(.MEM_WAIT(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    // Control word bit positions, MSB first.
    localparam logic [24:0] B_LD_MAR  = 25'd1 << 24;
    localparam logic [24:0] B_LD_MDR  = 25'd1 << 23;
    localparam logic [24:0] B_LD_IR   = 25'd1 << 22;
    localparam logic [24:0] B_LD_BEN  = 25'd1 << 21;
    localparam logic [24:0] B_LD_CC   = 25'd1 << 20;
    localparam logic [24:0] B_LD_REG  = 25'd1 << 19;
    localparam logic [24:0] B_LD_PC   = 25'd1 << 18;
    localparam logic [24:0] B_LD_LED  = 25'd1 << 17;
    localparam logic [24:0] B_GPC     = 25'd1 << 16;
    localparam logic [24:0] B_GMDR    = 25'd1 << 15;
    localparam logic [24:0] B_GALU    = 25'd1 << 14;
    localparam logic [24:0] B_GMARMUX = 25'd1 << 13;
    localparam logic [24:0] P_ADDER   = 25'd2 << 11;
    localparam logic [24:0] B_DR      = 25'd1 << 10;
    localparam logic [24:0] B_SR1     = 25'd1 << 9;
    localparam logic [24:0] B_ADDR1   = 25'd1 << 8;
    localparam logic [24:0] A2_SEXT6  = 25'd1 << 6;
    localparam logic [24:0] A2_SEXT9  = 25'd2 << 6;
    localparam logic [24:0] A2_SEXT11 = 25'd3 << 6;
    localparam logic [24:0] K_AND     = 25'd1 << 4;
    localparam logic [24:0] K_NOT     = 25'd2 << 4;
    localparam logic [24:0] K_PASS    = 25'd3 << 4;
    localparam logic [24:0] B_MIO     = 25'd1 << 3;
    localparam logic [24:0] IDLE      = 25'h7;  // CE_N, OE_N, WE_N high
    localparam logic [24:0] RD        = 25'h1;  // CE_N=0 OE_N=0 WE_N=1
    localparam logic [24:0] WR        = 25'h2;  // CE_N=0 OE_N=1 WE_N=0

    localparam logic [24:0] E_S18  = IDLE | B_GPC | B_LD_MAR | B_LD_PC;
    localparam logic [24:0] E_S35  = IDLE | B_GMDR | B_LD_IR;
    localparam logic [24:0] E_S32  = IDLE | B_LD_BEN;
    localparam logic [24:0] E_ALU  = IDLE | B_SR1 | B_DR | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_S22  = IDLE | B_ADDR1 | A2_SEXT9 | P_ADDER | B_LD_PC;
    localparam logic [24:0] E_S12  = IDLE | B_SR1 | P_ADDER | B_LD_PC;
    localparam logic [24:0] E_S04  = IDLE | B_GPC | B_LD_REG;
    localparam logic [24:0] E_S21  = IDLE | B_ADDR1 | A2_SEXT11 | P_ADDER | B_LD_PC;
    localparam logic [24:0] E_S67  = IDLE | B_SR1 | A2_SEXT6 | B_GMARMUX | B_LD_MAR;
    localparam logic [24:0] E_S27  = IDLE | B_GMDR | B_DR | B_LD_REG | B_LD_CC;
    localparam logic [24:0] E_S23  = IDLE | K_PASS | B_GALU | B_MIO | B_LD_MDR;
    localparam logic [24:0] E_P1   = IDLE | B_LD_LED;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    logic [24:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [24:0] obs();
        return {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG,
                bus.LD_PC, bus.LD_LED, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                bus.PCMUX, bus.DR, bus.SR1MUX, bus.ADDR1MUX, bus.ADDR2MUX, bus.ALUK,
                bus.MIO_EN, bus.Mem_CE_N, bus.Mem_OE_N, bus.Mem_WE_N};
    endfunction

    task automatic check(input string tag, input logic [24:0] o, input logic [24:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Queue the expected word for this cycle, compare at the falling edge, advance one cycle.
    task automatic cyc(input string tag, input logic [24:0] e);
        logic [24:0] o;
        logic [1:0]  inv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        o = obs();
        check(tag_q.pop_front(), o, exp_q.pop_front());
        inv = {($countones(o[16:13]) > 1), (o[1:0] == 2'b00)};
        check({tag, "_inv"}, {23'd0, inv}, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_s18"},  E_S18);
        cyc({tag, "_s33a"}, RD);
        cyc({tag, "_s33b"}, RD);
        cyc({tag, "_s33c"}, RD | B_LD_MDR);
        cyc({tag, "_s35"},  E_S35);
        cyc({tag, "_s32"},  E_S32);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; bus.Run = 1'b0; bus.Continue = 1'b0; bus.Opcode = 4'h0;
        bus.IR_5 = 1'b0; bus.IR_11 = 1'b0; bus.BEN = 1'b0;
        #2;
        check("reset_idle", obs(), IDLE);
        @(posedge clk); #1;
        reset = 1'b0;

        cyc("halted_norun", IDLE);
        bus.Run = 1'b1;
        cyc("halted_run", IDLE);

        bus.Opcode = OP_ADD;  fetch("add"); cyc("s01", E_ALU);
        bus.Opcode = OP_BR;   bus.BEN = 1'b0; fetch("brn"); cyc("s00_nt", IDLE);
        bus.BEN = 1'b1;       fetch("brt"); cyc("s00_t", IDLE); cyc("s22", E_S22);
        bus.Opcode = OP_AND;  fetch("and"); cyc("s05", E_ALU | K_AND);
        bus.Opcode = OP_NOT;  fetch("not"); cyc("s09", E_ALU | K_NOT);
        bus.Opcode = OP_JMP;  fetch("jmp"); cyc("s12", E_S12);
        bus.Opcode = OP_JSR;  bus.IR_11 = 1'b1; fetch("jsr"); cyc("s04a", E_S04); cyc("s21", E_S21);
        bus.IR_11 = 1'b0;     fetch("jsrr"); cyc("s04b", E_S04); cyc("s20", E_S12);

        bus.Opcode = OP_STR;  fetch("str");
        cyc("s07", E_S67); cyc("s23", E_S23);
        cyc("s16a", WR); cyc("s16b", WR); cyc("s16c", WR);

        bus.Opcode = OP_LDR;  fetch("ldr");
        cyc("s06", E_S67); cyc("s25a", RD); cyc("s25b", RD); cyc("s25c", RD | B_LD_MDR);
        cyc("s27", E_S27);

        // Run dropped mid-program and an undefined opcode: both just continue fetching.
        bus.Run = 1'b0; bus.Opcode = 4'b1111; fetch("nop");

        bus.Opcode = OP_PAUSE; fetch("pause1");
        cyc("p1_wait0", E_P1); cyc("p1_wait1", E_P1);
        bus.Continue = 1'b1;
        cyc("p1_go", E_P1);
        cyc("p2_h1", IDLE); cyc("p2_h2", IDLE); cyc("p2_h3", IDLE); cyc("p2_h4", IDLE);
        bus.Continue = 1'b0;
        cyc("p2_rel", IDLE);

        fetch("pause2");
        cyc("p1b_wait0", E_P1); cyc("p1b_wait1", E_P1);
        bus.Continue = 1'b1; cyc("p1b_go", E_P1);
        bus.Continue = 1'b0; cyc("p2b_rel", IDLE);

        // Reset asserted in the middle of the second S33 cycle.
        bus.Run = 1'b1; bus.Opcode = OP_ADD;
        cyc("rst_s18", E_S18);
        cyc("rst_s33a", RD);
        #1;
        check("rst_s33b_pre", obs(), RD);
        reset = 1'b1;
        #1;
        check("rst_async_idle", obs(), IDLE);
        n_cmp++;
        assert (dut.state_q === HALTED) else begin
            n_mis++;
            $error("FAIL rst_state: observed %0d expected %0d", dut.state_q, HALTED);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cyc("rst_halted", IDLE);
        cyc("rst_refetch", E_S18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/slc3_control.md
Name: slc3_control

Overview:
- Instruction sequencing unit (ISDU) for the SLC-3 CPU.
- Moore FSM that drives every load, gate and mux-select input of the SLC-3 datapath, plus the SRAM strobes.
- Implements fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE, with a programmable memory wait-state count.

Parameters:
MEM_WAIT, 3, cycles each SRAM read/write access is held; legal range 1..7

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces HALTED
Run  in  1  level; leaves HALTED when 1
Continue  in  1  level; PAUSE release handshake
Opcode  in  4  IR[15:12]
IR_5  in  1  IR[5]; not used by FSM, kept for tracing
IR_11  in  1  IR[11]; JSR (1) vs JSRR (0)
BEN  in  1  registered branch-enable from datapath
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high
PCMUX  out  2  00 PC+1, 01 bus, 10 adder
DR  out  1  0 selects R7, 1 selects IR[11:9]
SR1MUX  out  1  0 selects IR[11:9], 1 selects IR[8:6]
ADDR1MUX  out  1  0 SR1, 1 PC
ADDR2MUX  out  2  00 zero, 01 SEXT6, 10 SEXT9, 11 SEXT11
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS-A
MIO_EN  out  1  MDR source: 0 memory, 1 bus
Mem_CE_N, Mem_OE_N, Mem_WE_N  out  1 each  SRAM strobes, active-low

Behaviour:
- Outputs decode combinationally from state only (Moore); the state register and wait counter are async-reset.
- Default in every state: all outputs 0, except Mem_*_N = 1. This is also the value during and after reset.
- HALTED: moves to S18 when Run=1, otherwise stays.
- Fetch sequence:
  - S18: GatePC, LD_MAR, PCMUX=00, LD_PC.
  - S33: Mem_CE_N=0, Mem_OE_N=0, MIO_EN=0 for MEM_WAIT cycles; LD_MDR only in the final cycle.
  - S35: GateMDR, LD_IR.
  - S32: LD_BEN, then dispatch on Opcode.
  - Fetch-to-execute latency is MEM_WAIT+3 cycles.
- Dispatch:
  - 0001 → S01, 0101 → S05, 1001 → S09.
  - 0000 → S00, 1100 → S12, 0100 → S04.
  - 0110 → S06, 0111 → S07, 1101 → PAUSE1.
  - Any other opcode → S18 (treated as NOP).
- S01 / S05 / S09: SR1MUX=1, DR=1, GateALU, LD_REG, LD_CC; ALUK = 00 / 01 / 10 respectively. Next state S18.
- S00: BEN=1 → S22, else → S18.
- S22: ADDR1MUX=1, ADDR2MUX=10, PCMUX=10, LD_PC. Next S18.
- S12: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=00, PCMUX=10, LD_PC. Next S18.
- S04: GatePC, DR=0, LD_REG. Next S21 if IR_11=1, else S20.
- S21: ADDR1MUX=1, ADDR2MUX=11, PCMUX=10, LD_PC. S20: same as S12. Both go to S18.
- S06 / S07: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=01, GateMARMUX, LD_MAR.
- LDR path:
  - S25: read strobes as in S33 for MEM_WAIT cycles, LD_MDR in the last cycle.
  - S27: GateMDR, DR=1, LD_REG, LD_CC. Next S18.
- STR path:
  - S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=1, LD_MDR.
  - S16: Mem_CE_N=0, Mem_WE_N=0 for exactly MEM_WAIT cycles, Mem_OE_N=1. Next S18.
- Wait counter:
  - 3 bits; cleared on entry to S33/S25/S16; increments each cycle in those states.
  - Exit when count = MEM_WAIT-1. MEM_WAIT=1 gives a single-cycle state with LD_MDR.
- PAUSE:
  - PAUSE1: LD_LED; stays until Continue=1, then PAUSE2.
  - PAUSE2: stays until Continue=0, then S18. One held Continue press advances exactly one PAUSE.
- Run is sampled only in HALTED; deasserting Run mid-program has no effect.
- Reset mid-operation, including during memory states: state becomes HALTED, counter 0, and strobes go inactive without waiting for a clock edge.
- Invariant: at most one Gate* high in any state. Mem_WE_N and Mem_OE_N are never both 0.

Decomposition:
- Package slc3_pkg holds:
  - state_t enum;
  - opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LDR, OP_STR, OP_PAUSE);
  - ALUK_* codes;
  - PCMUX_*, ADDR2_* codes.
- Sub-module mem_wait_timer holds the wait counter: clear/enable inputs, done output, MEM_WAIT parameter.

Test Plan:
1. MEM_WAIT=3; reset, then Run=1 → HALTED, S18, S33×3, S35, S32. LD_MDR high only in cycle 5; LD_IR in cycle 6.
2. Opcode=0001 after fetch → one S01 cycle with ALUK=00, SR1MUX=1, DR=1, LD_REG=LD_CC=GateALU=1, then S18.
3. Opcode=0000 with BEN=0 → S00 then S18, LD_PC never high. Repeat with BEN=1 → S22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
4. Opcode=0111 → S07, S23 (MIO_EN=1, ALUK=11), then Mem_WE_N=0 for exactly 3 cycles with Mem_OE_N=1 throughout, then S18.
5. Opcode=1101, Continue held 1 for 5 cycles then 0 → LD_LED high until the first Continue cycle, one pass through PAUSE2, next fetch. A second PAUSE is not skipped.
6. reset asserted mid-cycle during the second S33 cycle → Mem_CE_N, Mem_OE_N return to 1 before the next edge; state HALTED; with Run=1 held, the next fetch starts at S18.
